alu_word_sequencer: RTL and testbench



---
 rtl/alu_word_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_word_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - issues an N-word operation to a W-bit ALU one slice per cycle
module alu_word_sequencer #(
    parameter int W = 4,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_opcode,
    input  logic [N*W-1:0] cmd_a,
    input  logic [N*W-1:0] cmd_b,
    input  logic           cmd_cin,
    input  logic           cmd_dir,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*W-1:0] res_y,
    output logic           res_cout,
    output logic           res_overflow,
    output logic           res_negative,
    output logic           res_zero,
    output logic [3:0]     alu_opcode,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_cin,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_cout,
    input  logic           alu_overflow,
    input  logic           alu_negative,
    input  logic           alu_zero
);
    localparam int KW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state, w_state_next;
    logic [KW-1:0]  r_k;
    logic           r_dir;
    logic [N*W-1:0] r_a, r_b;
    logic [N*W-1:0] r_acc_y, w_acc_y_next;
    logic           r_acc_zero, r_acc_ovf, r_acc_neg, r_last_cout;
    logic [N*W-1:0] r_res_y;
    logic           r_res_cout, r_res_ovf, r_res_neg, r_res_zero;
    logic [3:0]     r_alu_opcode;
    logic [W-1:0]   r_alu_a, r_alu_b;
    logic           r_alu_cin;
    logic           w_k_last, w_commit;
    int             w_cur_idx, w_nxt_idx;

    function automatic int word_idx(input logic dir, input int k);
        return dir ? (N - 1 - k) : k;
    endfunction

    // Out-of-range indices yield zero; only reachable for the unused look-ahead after the last slice.
    function automatic logic [W-1:0] get_word(input logic [N*W-1:0] v, input int idx);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++)
            if (i == idx) w = v[i*W +: W];
        return w;
    endfunction

    assign w_k_last  = (r_k == KW'(N - 1));
    assign w_commit  = (r_k == KW'(N));
    assign w_cur_idx = word_idx(r_dir, int'(r_k));
    assign w_nxt_idx = word_idx(r_dir, int'(r_k) + 1);

    always_comb begin
        w_acc_y_next = r_acc_y;
        for (int i = 0; i < N; i++)
            if (i == w_cur_idx) w_acc_y_next[i*W +: W] = alu_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_next = S_RUN;
            S_RUN:   if (w_commit)  w_state_next = S_DONE;
            S_DONE:  if (res_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        res_valid = (r_state == S_DONE);
    end

    // Slices accumulate in r_acc_*; the visible result only changes on the commit cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_dir        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc_y      <= '0;
            r_acc_zero   <= 1'b0;
            r_acc_ovf    <= 1'b0;
            r_acc_neg    <= 1'b0;
            r_last_cout  <= 1'b0;
            r_res_y      <= '0;
            r_res_cout   <= 1'b0;
            r_res_ovf    <= 1'b0;
            r_res_neg    <= 1'b0;
            r_res_zero   <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cin    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_a          <= cmd_a;
                    r_b          <= cmd_b;
                    r_dir        <= cmd_dir;
                    r_k          <= '0;
                    r_acc_y      <= '0;
                    r_acc_zero   <= 1'b1;
                    r_alu_opcode <= cmd_opcode;
                    r_alu_a      <= get_word(cmd_a, cmd_dir ? N - 1 : 0);
                    r_alu_b      <= get_word(cmd_b, cmd_dir ? N - 1 : 0);
                    r_alu_cin    <= cmd_cin;
                end
                S_RUN: if (w_commit) begin
                    r_res_y    <= r_acc_y;
                    r_res_cout <= r_last_cout;
                    r_res_ovf  <= r_acc_ovf;
                    r_res_neg  <= r_acc_neg;
                    r_res_zero <= r_acc_zero;
                end else begin
                    r_acc_y     <= w_acc_y_next;
                    r_acc_zero  <= r_acc_zero & alu_zero;
                    r_last_cout <= alu_cout;
                    r_k         <= r_k + 1'b1;
                    if (w_cur_idx == N - 1) begin
                        r_acc_ovf <= alu_overflow;
                        r_acc_neg <= alu_negative;
                    end
                    if (!w_k_last) begin
                        r_alu_a   <= get_word(r_a, w_nxt_idx);
                        r_alu_b   <= get_word(r_b, w_nxt_idx);
                        r_alu_cin <= alu_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_y        = r_res_y;
    assign res_cout     = r_res_cout;
    assign res_overflow = r_res_ovf;
    assign res_negative = r_res_neg;
    assign res_zero     = r_res_zero;
    assign alu_opcode   = r_alu_opcode;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_cin      = r_alu_cin;
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb/tb_alu_word_sequencer.sv - scoreboard bench for alu_word_sequencer with a stub adder ALU
module tb_alu_word_sequencer;
    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid, cmd_ready, cmd_cin, cmd_dir;
    logic [3:0]     cmd_opcode;
    logic [N*W-1:0] cmd_a, cmd_b;
    logic           res_valid, res_ready;
    logic [N*W-1:0] res_y;
    logic           res_cout, res_overflow, res_negative, res_zero;
    logic [3:0]     alu_opcode;
    logic [W-1:0]   alu_a, alu_b, alu_y;
    logic           alu_cin, alu_cout, alu_overflow, alu_negative, alu_zero;

    alu_word_sequencer #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_dir(cmd_dir),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_cout(res_cout), .res_overflow(res_overflow),
        .res_negative(res_negative), .res_zero(res_zero),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .alu_zero(alu_zero)
    );

    always_comb begin
        {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_zero     = (alu_y == 4'h0);
        alu_negative = alu_y[3];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
    end

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       cout, ovf, neg, zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xfer_cyc = 0;
    int   acc_cyc = 0;
    logic rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic dir);
        exp_t e;
        logic [8:0] s;
        logic [4:0] hi, lo;
        if (!dir) begin
            s      = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            e.y    = s[7:0];
            e.cout = s[8];
            e.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
        end else begin
            hi     = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, cin};
            lo     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, hi[4]};
            e.y    = {hi[3:0], lo[3:0]};
            e.cout = lo[4];
            e.ovf  = (a[7] == b[7]) && (hi[3] != a[7]);
        end
        e.neg  = e.y[7];
        e.zero = (e.y == 8'h00);
        return e;
    endfunction

    // Monitor: every result handshake is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            xfer_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(res_y), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {res_y, res_cout, res_overflow, res_negative, res_zero}, 32'(e));
            end
        end
    end

    always @(posedge clk) if (rand_ready) #1 res_ready = 1'($urandom);

    // Called and returning at posedge+1; the command is accepted on the edge inside.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic dir, input bit push);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_opcode = 4'($urandom);
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_dir = dir;
        if (push) sb.push_back(model(a, b, cin, dir));
        @(posedge clk); #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_valid;
        int guard = 0;
        while (!res_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   guard;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_dir = 1'b0; res_ready = 1'b1;
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", {res_y, res_cout, res_overflow, res_negative, res_zero}, 32'd0);
        chk("rst_alu", {alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        send(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("add_s0_alu", {alu_a, alu_b, alu_cin}, {4'hF, 4'h1, 1'b0});
        chk("add_s0_valid", 32'(res_valid), 32'd0);
        step();
        chk("add_s1_alu", {alu_a, alu_b, alu_cin}, {4'h0, 4'h0, 1'b1});
        chk("add_s1_valid", 32'(res_valid), 32'd0);
        step();
        chk("add_latency_early", 32'(res_valid), 32'd0);
        step();
        chk("add_latency", 32'(res_valid), 32'd1);
        step();

        send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_valid();
        step();

        send(8'h3A, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("dir_s0_alu_a", 32'(alu_a), 32'h3);
        step();
        chk("dir_s1_alu", {alu_a, alu_cin}, {4'hA, 1'b0});
        wait_valid();
        step();

        res_ready = 1'b0;
        e = model(8'h5C, 8'hA7, 1'b1, 1'b0);
        send(8'h5C, 8'hA7, 1'b1, 1'b0, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0] ? 1'b0 : 1'b1;
            cmd_a     = 8'($urandom);
            step();
            chk("bp_hold", {res_valid, cmd_ready, res_y}, {1'b1, 1'b0, e.y});
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk("bp_after_xfer", {cmd_ready, res_valid}, {1'b1, 1'b0});

        send(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_state", {cmd_ready, res_valid}, {1'b1, 1'b0});
        chk("abort_res_y", 32'(res_y), 32'd0);
        chk("abort_alu", {alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
        step();

        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("b2b_accept_cycle", 32'(acc_cyc), 32'(xfer_cyc + 2));
        wait_valid();
        step();

        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        rand_ready = 1'b0;
        res_ready  = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
